// File: rtl/sysid_boot_gate.sv
// Boot gate: reads the sysid ID/timestamp words over Avalon-MM and only releases
// the per-CPU resets, staggered, once both match the values this image was built for.
module sysid_boot_gate #(
    parameter int          NUM_CPUS           = 2,
    parameter logic [31:0] EXPECTED_ID        = 32'h0000_0000,
    parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1673199811,
    parameter int          READ_LATENCY       = 0,
    parameter int          MAX_RETRY          = 3,
    parameter int          BACKOFF_CYCLES     = 16,
    parameter int          STAGGER_CYCLES     = 8
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                recheck,
    output logic                avm_address,
    output logic                avm_read,
    input  logic                avm_waitrequest,
    input  logic [31:0]         avm_readdata,
    output logic [NUM_CPUS-1:0] cpu_release,
    output logic                boot_ok,
    output logic                id_error,
    output logic [3:0]          retry_count
);

    localparam int IW = $clog2(NUM_CPUS + 1);
    localparam int SW = STAGGER_CYCLES;
    localparam int BW = $clog2(BACKOFF_CYCLES + 1);

    typedef enum logic [3:0] {
        IDLE, RD_ID, WAIT_ID, RD_TS, WAIT_TS, COMPARE, BACKOFF, RELEASE, DONE, FAIL
    } state_t;

    state_t        state;
    logic [31:0]   id_q;
    logic [31:0]   ts_q;
    logic [1:0]    lat_cnt;
    logic [BW-1:0] bo_cnt;
    logic [SW-1:0] stag_cnt;
    logic [IW-1:0] cpu_idx;

    logic       accept;
    logic       match;
    logic [3:0] retry_next;

    assign accept     = avm_read && !avm_waitrequest;
    assign match      = (id_q == EXPECTED_ID) && (ts_q == EXPECTED_TIMESTAMP);
    assign retry_next = (retry_count == 4'hF) ? 4'hF : retry_count + 4'd1;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            avm_read    <= 1'b0;
            avm_address <= 1'b0;
            cpu_release <= '0;
            boot_ok     <= 1'b0;
            id_error    <= 1'b0;
            retry_count <= 4'd0;
            id_q        <= '0;
            ts_q        <= '0;
            lat_cnt     <= '0;
            bo_cnt      <= '0;
            stag_cnt    <= '0;
            cpu_idx     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    state       <= RD_ID;
                    avm_read    <= 1'b1;
                    avm_address <= 1'b0;
                end
                RD_ID: begin
                    if (accept) begin
                        if (READ_LATENCY == 0) begin
                            id_q        <= avm_readdata;
                            avm_address <= 1'b1;
                            state       <= RD_TS;
                        end else begin
                            avm_read <= 1'b0;
                            lat_cnt  <= 2'd1;
                            state    <= WAIT_ID;
                        end
                    end
                end
                WAIT_ID: begin
                    if (lat_cnt == 2'(READ_LATENCY)) begin
                        id_q        <= avm_readdata;
                        avm_read    <= 1'b1;
                        avm_address <= 1'b1;
                        state       <= RD_TS;
                    end else begin
                        lat_cnt <= lat_cnt + 2'd1;
                    end
                end
                RD_TS: begin
                    if (accept) begin
                        avm_read <= 1'b0;
                        if (READ_LATENCY == 0) begin
                            ts_q        <= avm_readdata;
                            avm_address <= 1'b0;
                            state       <= COMPARE;
                        end else begin
                            lat_cnt <= 2'd1;
                            state   <= WAIT_TS;
                        end
                    end
                end
                WAIT_TS: begin
                    if (lat_cnt == 2'(READ_LATENCY)) begin
                        ts_q        <= avm_readdata;
                        avm_address <= 1'b0;
                        state       <= COMPARE;
                    end else begin
                        lat_cnt <= lat_cnt + 2'd1;
                    end
                end
                COMPARE: begin
                    if (match) begin
                        state <= RELEASE;
                    end else begin
                        retry_count <= retry_next;
                        if (retry_next == 4'(MAX_RETRY)) begin
                            id_error <= 1'b1;
                            state    <= FAIL;
                        end else begin
                            bo_cnt <= '0;
                            state  <= BACKOFF;
                        end
                    end
                end
                BACKOFF: begin
                    if (bo_cnt == BW'(BACKOFF_CYCLES - 1)) begin
                        avm_read    <= 1'b1;
                        avm_address <= 1'b0;
                        state       <= RD_ID;
                    end else begin
                        bo_cnt <= bo_cnt + 1'b1;
                    end
                end
                RELEASE: begin
                    // cpu_idx counts CPUs already out of reset; it survives rechecks
                    // so a passing recheck falls straight through to DONE.
                    if (cpu_idx == IW'(NUM_CPUS)) begin
                        boot_ok <= 1'b1;
                        state   <= DONE;
                    end else if (cpu_idx == '0 || stag_cnt == SW'(STAGGER_CYCLES - 1)) begin
                        cpu_release <= cpu_release | (NUM_CPUS'(1) << cpu_idx);
                        cpu_idx     <= cpu_idx + 1'b1;
                        stag_cnt    <= '0;
                    end else begin
                        stag_cnt <= stag_cnt + 1'b1;
                    end
                end
                DONE, FAIL: begin
                    if (recheck) begin
                        boot_ok     <= 1'b0;
                        retry_count <= 4'd0;
                        avm_read    <= 1'b1;
                        avm_address <= 1'b0;
                        state       <= RD_ID;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sysid_boot_gate.sv
// Directed bench for sysid_boot_gate: a zero-latency instance with a stallable
// slave and a two-cycle-latency instance whose slave drives garbage outside the data cycle.
module tb_sysid_boot_gate;

    localparam logic [31:0] EXP_ID = 32'h0000_0000;
    localparam logic [31:0] EXP_TS = 32'd1673199811;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic reset_n;

    // Instance 0: READ_LATENCY=0
    logic        recheck0, addr0, read0, wait0, ok0, err0;
    logic [31:0] rdata0;
    logic [1:0]  rel0;
    logic [3:0]  rc0;
    logic [31:0] id_val, ts_val;
    logic        wait_hold;

    assign wait0  = wait_hold && read0 && addr0;
    assign rdata0 = addr0 ? ts_val : id_val;

    sysid_boot_gate #(.READ_LATENCY(0)) u0 (
        .clock(clock), .reset_n(reset_n), .recheck(recheck0),
        .avm_address(addr0), .avm_read(read0), .avm_waitrequest(wait0),
        .avm_readdata(rdata0), .cpu_release(rel0), .boot_ok(ok0),
        .id_error(err0), .retry_count(rc0)
    );

    // Instance 2: READ_LATENCY=2, data valid only two cycles after acceptance
    logic        recheck2, addr2, read2, wait2, ok2, err2;
    logic [31:0] rdata2;
    logic [1:0]  rel2;
    logic [3:0]  rc2;
    logic [1:0]  pv, pa;

    assign recheck2 = 1'b0;
    assign wait2    = 1'b0;
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pv <= 2'b00;
            pa <= 2'b00;
        end else begin
            pv <= {pv[0], read2};
            pa <= {pa[0], addr2};
        end
    end
    assign rdata2 = pv[1] ? (pa[1] ? EXP_TS : EXP_ID) : 32'hDEAD_BEEF;

    sysid_boot_gate #(.READ_LATENCY(2)) u2 (
        .clock(clock), .reset_n(reset_n), .recheck(recheck2),
        .avm_address(addr2), .avm_read(read2), .avm_waitrequest(wait2),
        .avm_readdata(rdata2), .cpu_release(rel2), .boot_ok(ok2),
        .id_error(err2), .retry_count(rc2)
    );

    // Acceptance log for instance 0
    int   acc_n = 0;
    logic acc_addr [0:255];
    always @(posedge clock) begin
        if (reset_n && read0 && !wait0) begin
            acc_addr[acc_n[7:0]] <= addr0;
            acc_n <= acc_n + 1;
        end
    end

    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;
    int   rd_ptr = 0;
    logic exp_q [$];
    logic relbad;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_acc(input string tag);
        check({tag, "_count"}, acc_n - rd_ptr, exp_q.size());
        while (exp_q.size() > 0 && rd_ptr < acc_n) begin
            check({tag, "_addr"}, {31'd0, acc_addr[rd_ptr[7:0]]}, {31'd0, exp_q.pop_front()});
            rd_ptr++;
        end
        exp_q.delete();
        rd_ptr = acc_n;
    endtask

    task automatic step();
        @(negedge clock);
        cyc++;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clock);
        rd_ptr = acc_n;
    endtask

    task automatic deassert();
        reset_n = 1'b1;
        cyc = 0;
    endtask

    initial begin
        reset_n   = 1'b0;
        recheck0  = 1'b0;
        wait_hold = 1'b0;
        id_val    = EXP_ID;
        ts_val    = EXP_TS;
        repeat (3) @(negedge clock);

        check("rst_read", read0, 0);
        check("rst_addr", addr0, 0);
        check("rst_rel", rel0, 0);
        check("rst_ok", ok0, 0);
        check("rst_err", err0, 0);
        check("rst_retry", rc0, 0);
        check("rst_rel2", rel2, 0);

        // Nominal boot, both instances
        exp_q = {1'b0, 1'b1};
        deassert();
        while (cyc < 20) begin
            step();
            if (cyc == 4)  check("nom_rel_c4", rel0, 2'b00);
            if (cyc == 5)  check("nom_rel_c5", rel0, 2'b01);
            if (cyc == 12) check("nom_rel_c12", rel0, 2'b01);
            if (cyc == 13) begin check("nom_rel_c13", rel0, 2'b11); check("nom_ok_c13", ok0, 0); end
            if (cyc == 14) begin check("nom_ok_c14", ok0, 1); check("nom_err", err0, 0); end
            if (cyc == 8)  check("lat_rel_c8", rel2, 2'b00);
            if (cyc == 9)  check("lat_rel_c9", rel2, 2'b01);
            if (cyc == 17) begin check("lat_rel_c17", rel2, 2'b11); check("lat_ok_c17", ok2, 0); end
            if (cyc == 18) begin check("lat_ok_c18", ok2, 1); check("lat_err", err2, 0); end
        end
        check_acc("nom_acc");

        // Waitrequest stall of 5 cycles on the timestamp read
        do_reset();
        wait_hold = 1'b1;
        exp_q = {1'b0, 1'b1};
        deassert();
        while (cyc < 22) begin
            step();
            if (cyc >= 2 && cyc <= 7) begin
                check("stall_read", read0, 1);
                check("stall_addr", addr0, 1);
            end
            if (cyc == 7)  wait_hold = 1'b0;
            if (cyc == 9)  check("stall_rel_c9", rel0, 2'b00);
            if (cyc == 10) check("stall_rel_c10", rel0, 2'b01);
            if (cyc == 17) check("stall_rel_c17", rel0, 2'b01);
            if (cyc == 18) begin check("stall_rel_c18", rel0, 2'b11); check("stall_ok_c18", ok0, 0); end
            if (cyc == 19) check("stall_ok_c19", ok0, 1);
        end
        check_acc("stall_acc");

        // Persistent timestamp mismatch; a recheck during BACKOFF is dropped
        do_reset();
        ts_val = 32'h1234_5678;
        exp_q = {1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        relbad = 1'b0;
        deassert();
        while (cyc < 80) begin
            step();
            if (rel0 != 2'b00) relbad = 1'b1;
            if (cyc == 30) recheck0 = 1'b1;
            if (cyc == 31) recheck0 = 1'b0;
            if (cyc == 4)  check("mis_retry_c4", rc0, 1);
            if (cyc == 19) begin check("mis_retry_c19", rc0, 1); check("mis_read_c19", read0, 0); end
            if (cyc == 20) begin check("mis_read_c20", read0, 1); check("mis_addr_c20", addr0, 0); end
            if (cyc == 23) check("mis_retry_c23", rc0, 2);
            if (cyc == 41) check("mis_err_c41", err0, 0);
            if (cyc == 42) begin check("mis_retry_c42", rc0, 3); check("mis_err_c42", err0, 1); end
        end
        check("mis_rel_never", relbad, 0);
        check("mis_read_idle", read0, 0);
        check("mis_ok", ok0, 0);
        check_acc("mis_acc");

        // Transient ID mismatch on the first pass only
        do_reset();
        ts_val = EXP_TS;
        id_val = 32'hBAD0_BAD0;
        exp_q = {1'b0, 1'b1, 1'b0, 1'b1};
        deassert();
        while (cyc < 36) begin
            step();
            if (cyc == 4)  begin id_val = EXP_ID; check("tr_retry_c4", rc0, 1); end
            if (cyc == 23) check("tr_rel_c23", rel0, 2'b00);
            if (cyc == 24) check("tr_rel_c24", rel0, 2'b01);
            if (cyc == 32) check("tr_rel_c32", rel0, 2'b11);
            if (cyc == 33) begin check("tr_ok_c33", ok0, 1); check("tr_retry", rc0, 1); check("tr_err", err0, 0); end
        end
        check_acc("tr_acc");

        // Reset in the middle of RELEASE
        do_reset();
        exp_q = {1'b0, 1'b1};
        deassert();
        while (cyc < 7) begin
            step();
            if (cyc == 6) check("mid_rel_c6", rel0, 2'b01);
        end
        check_acc("mid_acc1");
        #2 reset_n = 1'b0;
        #1;
        check("mid_async_rel", rel0, 0);
        check("mid_async_read", read0, 0);
        check("mid_async_ok", ok0, 0);
        check("mid_async_retry", rc0, 0);
        @(negedge clock);
        rd_ptr = acc_n;
        exp_q = {1'b0, 1'b1};
        deassert();
        while (cyc < 16) begin
            step();
            if (cyc == 5)  check("mid_rel_c5", rel0, 2'b01);
            if (cyc == 13) check("mid_rel_c13", rel0, 2'b11);
            if (cyc == 14) check("mid_ok_c14", ok0, 1);
        end
        check_acc("mid_acc2");

        // Recheck from DONE against a corrupted sysid; recheck in RD_TS is dropped
        ts_val   = 32'h0BAD_F00D;
        recheck0 = 1'b1;
        exp_q = {1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        relbad = 1'b0;
        while (cyc < 62) begin
            step();
            recheck0 = 1'b0;
            if (rel0 != 2'b11) relbad = 1'b1;
            if (cyc == 17) begin
                check("rc_ok_c17", ok0, 0);
                check("rc_read_c17", read0, 1);
                check("rc_addr_c17", addr0, 0);
            end
            if (cyc == 18) begin check("rc_addr_c18", addr0, 1); recheck0 = 1'b1; end
            if (cyc == 57) check("rc_err_c57", err0, 0);
            if (cyc == 58) begin check("rc_err_c58", err0, 1); check("rc_retry_c58", rc0, 3); end
        end
        check("rc_cpus_kept", relbad, 0);
        check("rc_ok_fail", ok0, 0);
        check_acc("rc_acc");

        // Recheck from FAIL with a good sysid
        ts_val   = EXP_TS;
        recheck0 = 1'b1;
        exp_q = {1'b0, 1'b1};
        while (cyc < 70) begin
            step();
            recheck0 = 1'b0;
            if (cyc == 63) begin check("rf_retry_c63", rc0, 0); check("rf_read_c63", read0, 1); end
            if (cyc == 66) check("rf_ok_c66", ok0, 0);
            if (cyc == 67) begin
                check("rf_ok_c67", ok0, 1);
                check("rf_rel", rel0, 2'b11);
                check("rf_err_sticky", err0, 1);
            end
        end
        check_acc("rf_acc");
        check("lat_final_ok", ok2, 1);
        check("lat_final_retry", rc2, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sysid_boot_gate.md
Name: sysid_boot_gate

Overview:
- Avalon-MM master that consumes the system-ID peripheral's control_slave.
- After reset it reads the ID word (address 0) and the timestamp word (address 1), then compares both against build-time expected values.
- On a match it releases the per-CPU reset lines one at a time, with a programmable stagger between CPUs.
- On a mismatch it retries a bounded number of times, then latches an error. Processors therefore never boot against a stale or mismatched hardware image.

Parameters:
- NUM_CPUS, 2, number of processor reset-release outputs (1..8).
- EXPECTED_ID, 32'h00000000, value required at sysid address 0.
- EXPECTED_TIMESTAMP, 32'd1673199811, value required at sysid address 1.
- READ_LATENCY, 0, cycles from read acceptance to valid readdata (0..3; 0 = same cycle).
- MAX_RETRY, 3, mismatching check passes allowed before FAIL (1..15).
- BACKOFF_CYCLES, 16, idle cycles between failed passes (>=1).
- STAGGER_CYCLES, 8, cycles between successive CPU releases (>=1).

Ports:
- clock  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- recheck  in  1  single-cycle pulse; in DONE or FAIL it restarts the check. Ignored in all other states.
- avm_address  out  1  sysid word select.
- avm_read  out  1  read request.
- avm_waitrequest  in  1  slave stall.
- avm_readdata  in  32  read data.
- cpu_release  out  NUM_CPUS  bit i high = CPU i out of reset.
- boot_ok  out  1  high while in DONE.
- id_error  out  1  sticky mismatch error.
- retry_count  out  4  failed passes in the current attempt.

Behaviour:
- Reset state, all outputs: state=IDLE; avm_read=0, avm_address=0, cpu_release=0, boot_ok=0, id_error=0, retry_count=0.
- The asynchronous reset overrides every state. Reset mid-operation drops all cpu_release bits immediately and abandons any read in progress.
- States: IDLE, RD_ID, WAIT_ID, RD_TS, WAIT_TS, COMPARE, BACKOFF, RELEASE, DONE, FAIL.
- IDLE: moves to RD_ID one cycle after reset deassertion.
- RD_ID / RD_TS handshake:
  - Drive avm_read=1 with address 0 (RD_ID) or 1 (RD_TS).
  - Hold avm_read and avm_address stable while avm_waitrequest=1.
  - Acceptance is the cycle with avm_read=1 and avm_waitrequest=0.
- Data capture: readdata is captured READ_LATENCY cycles after acceptance, into id_q or ts_q.
  - READ_LATENCY=0: capture in the acceptance cycle; go directly to RD_TS (after ID) or COMPARE (after TS).
  - Otherwise: deassert avm_read after acceptance, spend READ_LATENCY cycles in WAIT_x, then capture.
- COMPARE (one cycle):
  - Both words match: go to RELEASE.
  - Else: retry_count += 1.
    - If the new value equals MAX_RETRY: go to FAIL and set id_error.
    - Otherwise: go to BACKOFF.
- BACKOFF: counts BACKOFF_CYCLES, then goes to RD_ID. retry_count is held.
- RELEASE:
  - On entry, set cpu_release[0].
  - Every STAGGER_CYCLES thereafter, set the next bit, in order 0..NUM_CPUS-1.
  - When the last bit is set, go to DONE the next cycle.
  - Released bits stay high; they are cleared only by reset.
- DONE: boot_ok=1. recheck goes to RD_ID and clears retry_count; cpu_release is kept.
- Recheck from DONE:
  - If the new check fails up to MAX_RETRY, go to FAIL, set id_error, and keep CPUs running.
  - If it passes, RELEASE sees all bits already set and goes straight to DONE after one cycle.
- FAIL: terminal except for recheck, which clears retry_count, goes to RD_ID, and keeps id_error sticky until reset.
- recheck arriving in any state other than DONE/FAIL is dropped.
- Counters saturate; no wrap-around. The stagger counter is STAGGER_CYCLES wide; the CPU index is ceil(log2(NUM_CPUS+1)) bits wide.
- Exactly one read is outstanding at any time. avm_read is never asserted in COMPARE, BACKOFF, RELEASE, DONE or FAIL.

Test Plan:
- Nominal boot (NUM_CPUS=2, READ_LATENCY=0, STAGGER_CYCLES=8, slave returns 0 / 1673199811, no waitrequest):
  - cpu_release=01 at cycle 5 after reset release, 11 at cycle 13, boot_ok=1 at cycle 14, id_error=0.
- Waitrequest stall (avm_waitrequest high 5 cycles on the address-1 read):
  - avm_read and avm_address=1 held stable all 5 cycles; a single acceptance; release delayed by exactly 5 cycles.
- Latency (READ_LATENCY=2):
  - readdata that is valid only 2 cycles after acceptance is captured correctly.
  - Garbage driven on readdata in the acceptance cycle is ignored; boot succeeds.
- Persistent mismatch (timestamp returns 32'h12345678, MAX_RETRY=3, BACKOFF_CYCLES=16):
  - Three read pairs separated by 16-cycle gaps; retry_count steps 1, 2, 3; id_error=1; cpu_release=0 forever.
- Transient mismatch (first pass wrong ID, second pass correct):
  - retry_count=1, then RELEASE proceeds normally; id_error=0.
- Reset mid-RELEASE (reset_n low after cpu_release=01):
  - All outputs return to reset values asynchronously; a full boot repeats after reset deassertion.
- Recheck from DONE with corrupted sysid:
  - Ends in FAIL with id_error=1 and cpu_release still all-ones.
  - A recheck pulse in RD_TS has no effect.
